// File: rtl/decimating_averager.sv
// Boxcar decimator: averages blocks of 2^k signed samples and emits one mean
// per block with a one-cycle strobe, so that downstream logic can run at the
// decimated rate.
module decimating_averager #(
    parameter int WIDTH               = 14,
    parameter int LOG2_MAX_DECIMATION = 8,
    parameter int KW                  = $clog2(LOG2_MAX_DECIMATION + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [KW-1:0]    log2_decimation_i,
    input  logic             restart_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             ce_o
);

    localparam int AW = WIDTH + LOG2_MAX_DECIMATION;
    localparam int CW = LOG2_MAX_DECIMATION;

    logic signed [AW-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [KW-1:0]        k_act_q, k_act_d;
    logic [WIDTH-1:0]     data_o_q, data_o_d;
    logic                 ce_o_q, ce_o_d;

    logic [KW-1:0]        k_req;
    logic [KW-1:0]        k_cur;
    logic                 block_start;
    logic [CW:0]          span;
    logic [CW-1:0]        last_cnt;
    logic signed [AW-1:0] data_ext;
    logic signed [AW-1:0] acc_base;
    logic signed [AW-1:0] sum;
    logic                 block_end;

    // Clamp the request, pick the k governing this cycle, and form the running sum.
    always_comb begin
        if (log2_decimation_i > KW'(LOG2_MAX_DECIMATION)) begin
            k_req = KW'(LOG2_MAX_DECIMATION);
        end else begin
            k_req = log2_decimation_i;
        end
        // A block start (or restart) uses the fresh request right away so that
        // k = 0 can close a block on its very first sample.
        block_start = (cnt_q == '0) || restart_i;
        k_cur       = block_start ? k_req : k_act_q;
        span        = (CW + 1)'(1) << k_cur;
        last_cnt    = CW'(span - (CW + 1)'(1));
        data_ext    = {{LOG2_MAX_DECIMATION{data_i[WIDTH-1]}}, data_i};
        acc_base    = restart_i ? '0 : acc_q;
        sum         = acc_base + data_ext;
        // After a restart the current sample is sample 0, so the count compared
        // is zero rather than the stale pre-restart value.
        block_end   = restart_i ? (k_req == '0) : (cnt_q == last_cnt);
    end

    // Next-state: accumulate, or close the block and publish the floored mean.
    always_comb begin
        k_act_d  = block_start ? k_req : k_act_q;
        data_o_d = data_o_q;
        ce_o_d   = 1'b0;
        if (block_end) begin
            data_o_d = WIDTH'(sum >>> k_cur);
            ce_o_d   = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
        end else begin
            acc_d = sum;
            cnt_d = restart_i ? CW'(1) : cnt_q + CW'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            k_act_q  <= '0;
            data_o_q <= '0;
            ce_o_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            k_act_q  <= k_act_d;
            data_o_q <= data_o_d;
            ce_o_q   <= ce_o_d;
        end
    end

    assign data_o = data_o_q;
    assign ce_o   = ce_o_q;

endmodule

// File: tb/tb_decimating_averager.sv
// Directed bench for decimating_averager: each task drives one scenario and
// checks strobe timing and block means against hand-computed values.
module tb_decimating_averager;

    logic                     clk;
    logic                     rst_i;
    logic [3:0]               log2_decimation_i;
    logic                     restart_i;
    logic signed [13:0]       data_i;
    logic [13:0]              data_o;
    logic                     ce_o;

    int checks;
    int passes;

    decimating_averager dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .log2_decimation_i (log2_decimation_i),
        .restart_i         (restart_i),
        .data_i            (data_i),
        .data_o            (data_o),
        .ce_o              (ce_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample, let it be clocked in, and return just after the edge.
    task automatic cycle(input logic signed [13:0] d);
        data_i = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        restart_i = 1'b0;
        log2_decimation_i = 4'd2;
        data_i = 14'sd0;
        #20;
        checks++;
        if (data_o !== 14'd0 || ce_o !== 1'b0)
            $display("FAIL reset_values data_o=%0d ce_o=%0b want 0/0", $signed(data_o), ce_o);
        else passes++;
        #3 rst_i = 1'b0;
    endtask

    task automatic test_constant;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                cycle(14'sd10);
                checks++;
                if (ce_o !== (i == 3))
                    $display("FAIL const_ce blk%0d s%0d ce_o=%0b want %0b", b, i, ce_o, (i == 3));
                else passes++;
            end
            checks++;
            if ($signed(data_o) !== 14'sd10)
                $display("FAIL const_data blk%0d data_o=%0d want 10", b, $signed(data_o));
            else passes++;
        end
    endtask

    task automatic test_floor;
        logic signed [13:0] va [4];
        logic signed [13:0] vb [4];
        va = '{-14'sd2, -14'sd1, 14'sd0, 14'sd1};
        vb = '{14'sd1, 14'sd2, 14'sd3, 14'sd3};
        for (int i = 0; i < 4; i++) cycle(va[i]);
        checks++;
        if (ce_o !== 1'b1 || $signed(data_o) !== -14'sd1)
            $display("FAIL floor_neg data_o=%0d ce_o=%0b want -1/1", $signed(data_o), ce_o);
        else passes++;
        for (int i = 0; i < 4; i++) cycle(vb[i]);
        checks++;
        if (ce_o !== 1'b1 || $signed(data_o) !== 14'sd2)
            $display("FAIL floor_pos data_o=%0d ce_o=%0b want 2/1", $signed(data_o), ce_o);
        else passes++;
    endtask

    task automatic test_full_scale;
        logic signed [13:0] vals [3];
        logic [3:0]         ks   [3];
        int                 early;
        vals = '{14'sd8191, -14'sd8192, 14'sd1000};
        ks   = '{4'd8, 4'd8, 4'd15};
        for (int b = 0; b < 3; b++) begin
            log2_decimation_i = ks[b];
            early = 0;
            for (int i = 0; i < 256; i++) begin
                cycle(vals[b]);
                if (i < 255 && ce_o) early++;
            end
            checks++;
            if (early !== 0)
                $display("FAIL full_early blk%0d early_strobes=%0d want 0", b, early);
            else passes++;
            checks++;
            if (ce_o !== 1'b1 || $signed(data_o) !== vals[b])
                $display("FAIL full_data blk%0d data_o=%0d ce_o=%0b want %0d/1", b, $signed(data_o), ce_o, vals[b]);
            else passes++;
        end
    endtask

    task automatic test_k_change;
        logic signed [13:0] pt [3];
        pt = '{14'sd3, -14'sd4, 14'sd9};
        log2_decimation_i = 4'd3;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) log2_decimation_i = 4'd1;
            cycle(14'(i));
            checks++;
            if (ce_o !== (i == 7))
                $display("FAIL kchg_ce s%0d ce_o=%0b want %0b", i, ce_o, (i == 7));
            else passes++;
        end
        checks++;
        if ($signed(data_o) !== 14'sd3)
            $display("FAIL kchg_data data_o=%0d want 3", $signed(data_o));
        else passes++;
        cycle(14'sd5);
        checks++;
        if (ce_o !== 1'b0) $display("FAIL k1_gap ce_o=%0b want 0", ce_o);
        else passes++;
        cycle(14'sd6);
        checks++;
        if (ce_o !== 1'b1 || $signed(data_o) !== 14'sd5)
            $display("FAIL k1_data data_o=%0d ce_o=%0b want 5/1", $signed(data_o), ce_o);
        else passes++;
        log2_decimation_i = 4'd0;
        for (int i = 0; i < 3; i++) begin
            cycle(pt[i]);
            checks++;
            if (ce_o !== 1'b1 || $signed(data_o) !== pt[i])
                $display("FAIL k0_pass s%0d data_o=%0d ce_o=%0b want %0d/1", i, $signed(data_o), ce_o, pt[i]);
            else passes++;
        end
    endtask

    task automatic test_restart;
        logic signed [13:0] v [6];
        v = '{14'sd100, 14'sd100, 14'sd4, 14'sd4, 14'sd4, 14'sd4};
        log2_decimation_i = 4'd2;
        for (int i = 0; i < 6; i++) begin
            restart_i = (i == 2);
            cycle(v[i]);
            checks++;
            if (ce_o !== (i == 5))
                $display("FAIL rst_abort_ce s%0d ce_o=%0b want %0b", i, ce_o, (i == 5));
            else passes++;
        end
        restart_i = 1'b0;
        checks++;
        if ($signed(data_o) !== 14'sd4)
            $display("FAIL restart_data data_o=%0d want 4", $signed(data_o));
        else passes++;
        // Restart landing on the sample that would close a block.
        for (int i = 0; i < 7; i++) begin
            restart_i = (i == 3);
            cycle(i < 3 ? 14'sd8 : 14'sd20);
            checks++;
            if (ce_o !== (i == 6))
                $display("FAIL restart_end_ce s%0d ce_o=%0b want %0b", i, ce_o, (i == 6));
            else passes++;
        end
        restart_i = 1'b0;
        checks++;
        if ($signed(data_o) !== 14'sd20)
            $display("FAIL restart_end_data data_o=%0d want 20", $signed(data_o));
        else passes++;
        // Restart with k = 0 still emits the pass-through strobe.
        log2_decimation_i = 4'd0;
        restart_i = 1'b1;
        cycle(14'sd55);
        restart_i = 1'b0;
        checks++;
        if (ce_o !== 1'b1 || $signed(data_o) !== 14'sd55)
            $display("FAIL restart_k0 data_o=%0d ce_o=%0b want 55/1", $signed(data_o), ce_o);
        else passes++;
    endtask

    task automatic test_reset_mid_block;
        log2_decimation_i = 4'd3;
        for (int i = 0; i < 5; i++) cycle(14'sd50);
        #3 rst_i = 1'b1;
        #1;
        checks++;
        if (data_o !== 14'd0 || ce_o !== 1'b0)
            $display("FAIL async_reset data_o=%0d ce_o=%0b want 0/0", $signed(data_o), ce_o);
        else passes++;
        #10 rst_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(14'(i + 1));
            checks++;
            if (ce_o !== (i == 7))
                $display("FAIL post_reset_ce s%0d ce_o=%0b want %0b", i, ce_o, (i == 7));
            else passes++;
        end
        checks++;
        if ($signed(data_o) !== 14'sd4)
            $display("FAIL post_reset_data data_o=%0d want 4", $signed(data_o));
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset;
        test_constant;
        test_floor;
        test_full_scale;
        test_k_change;
        test_restart;
        test_reset_mid_block;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
